// File: rtl/mem_tg2_cycle_mon.sv
// Per-channel run monitor for the TG2 traffic generators: measures elapsed run cycles
// and raises a watchdog flag when a run reaches the programmed cycle limit.
module mem_tg2_cycle_mon #(
  parameter int unsigned NUM_TG = 4,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_TG-1:0] mem_tg_active,
  input  logic [NUM_TG-1:0] tg_pass_in,
  input  logic [NUM_TG-1:0] tg_fail_in,
  input  logic [31:0]       timeout_limit,
  output logic [CNT_W-1:0]  clock_count [NUM_TG],
  output logic [NUM_TG-1:0] tg_timeout,
  output logic [NUM_TG-1:0] tg_busy
);

  // Compare width is wide enough that counts at or beyond 2^32 never match a 32-bit limit.
  localparam int unsigned ExtW = (CNT_W > 32) ? CNT_W : 33;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  for (genvar g = 0; g < NUM_TG; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [ExtW-1:0]  inc_ext;
    logic             to_q, to_d;
    logic             act_q, act_d;
    logic             start;
    logic             hit;
    logic             finish;

    assign start   = mem_tg_active[g] & ~act_q;
    assign finish  = tg_pass_in[g] | tg_fail_in[g];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    assign inc_ext = ExtW'(cnt_inc);
    assign hit     = (timeout_limit != 32'd0) && (inc_ext == ExtW'(timeout_limit));

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      act_d   = mem_tg_active[g];
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d = StRun;
            cnt_d   = '0;
            to_d    = 1'b0;
          end
        end
        StRun: begin
          // Pass/fail outranks both abort and the watchdog; the finishing cycle is not counted.
          if (finish) begin
            state_d = StDone;
          end else if (!mem_tg_active[g]) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_inc;
            if (hit) begin
              to_d    = 1'b1;
              state_d = StDone;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        to_q    <= 1'b0;
        act_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        to_q    <= to_d;
        act_q   <= act_d;
      end
    end

    assign clock_count[g] = cnt_q;
    assign tg_timeout[g]  = to_q;
    assign tg_busy[g]     = (state_q == StRun);
  end

endmodule

// File: tb/tb_mem_tg2_cycle_mon.sv
// Directed bench for mem_tg2_cycle_mon: run, watchdog, tie-break, restart, abort, reset,
// channel independence, and counter saturation on a narrow instance.
module tb_mem_tg2_cycle_mon;

  logic        clk;
  logic        rst;
  logic [3:0]  active;
  logic [3:0]  pass_in;
  logic [3:0]  fail_in;
  logic [31:0] limit;
  logic [63:0] cc [4];
  logic [3:0]  tmo;
  logic [3:0]  busy;

  logic        s_active;
  logic        s_pass;
  logic        s_fail;
  logic [7:0]  s_cc [1];
  logic        s_tmo;
  logic        s_busy;

  int vectors;
  int miscompares;

  mem_tg2_cycle_mon #(
    .NUM_TG(4),
    .CNT_W (64)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .mem_tg_active(active),
    .tg_pass_in   (pass_in),
    .tg_fail_in   (fail_in),
    .timeout_limit(limit),
    .clock_count  (cc),
    .tg_timeout   (tmo),
    .tg_busy      (busy)
  );

  mem_tg2_cycle_mon #(
    .NUM_TG(1),
    .CNT_W (8)
  ) u_sat (
    .clk          (clk),
    .rst          (rst),
    .mem_tg_active(s_active),
    .tg_pass_in   (s_pass),
    .tg_fail_in   (s_fail),
    .timeout_limit(32'd0),
    .clock_count  (s_cc),
    .tg_timeout   (s_tmo),
    .tg_busy      (s_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    active      = '0;
    pass_in     = '0;
    fail_in     = '0;
    limit       = '0;
    s_active    = 1'b0;
    s_pass      = 1'b0;
    s_fail      = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_count%0d", i), cc[i], 64'd0);
    end
    chk("rst_timeout", 64'(tmo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick(1);

    // Basic run on channel 0, no watchdog.
    active[0] = 1'b1;
    tick(1);
    chk("run0_busy_start", 64'(busy[0]), 64'd1);
    chk("run0_count_start", cc[0], 64'd0);
    tick(99);
    chk("run0_count_99", cc[0], 64'd99);
    pass_in[0] = 1'b1;
    tick(1);
    chk("run0_count_frozen", cc[0], 64'd99);
    chk("run0_busy_stop", 64'(busy[0]), 64'd0);
    chk("run0_timeout", 64'(tmo[0]), 64'd0);
    pass_in[0] = 1'b0;
    tick(5);
    chk("run0_count_hold", cc[0], 64'd99);
    active[0] = 1'b0;
    tick(1);

    // Watchdog on channel 1.
    limit     = 32'd50;
    active[1] = 1'b1;
    tick(1);
    tick(49);
    chk("wd1_count_49", cc[1], 64'd49);
    chk("wd1_busy_49", 64'(busy[1]), 64'd1);
    chk("wd1_tmo_49", 64'(tmo[1]), 64'd0);
    tick(1);
    chk("wd1_count_50", cc[1], 64'd50);
    chk("wd1_tmo_50", 64'(tmo[1]), 64'd1);
    chk("wd1_busy_50", 64'(busy[1]), 64'd0);
    tick(1000);
    chk("wd1_count_hold", cc[1], 64'd50);
    chk("wd1_tmo_hold", 64'(tmo[1]), 64'd1);

    // Fail on the watchdog-hit cycle wins on channel 2.
    limit     = 32'd20;
    active[2] = 1'b1;
    tick(1);
    tick(19);
    chk("tie2_count_19", cc[2], 64'd19);
    fail_in[2] = 1'b1;
    tick(1);
    chk("tie2_tmo", 64'(tmo[2]), 64'd0);
    chk("tie2_count", cc[2], 64'd19);
    chk("tie2_busy", 64'(busy[2]), 64'd0);
    fail_in[2] = 1'b0;
    active[2]  = 1'b0;
    tick(25);
    chk("tie2_count_hold", cc[2], 64'd19);
    chk("tie2_tmo_hold", 64'(tmo[2]), 64'd0);

    // Restart channel 1 from DONE.
    limit     = 32'd0;
    active[1] = 1'b0;
    tick(1);
    chk("rs1_tmo_kept", 64'(tmo[1]), 64'd1);
    chk("rs1_count_kept", cc[1], 64'd50);
    active[1] = 1'b1;
    tick(1);
    chk("rs1_busy", 64'(busy[1]), 64'd1);
    chk("rs1_tmo_clr", 64'(tmo[1]), 64'd0);
    chk("rs1_count0", cc[1], 64'd0);
    tick(10);
    pass_in[1] = 1'b1;
    tick(1);
    chk("rs1_count10", cc[1], 64'd10);
    chk("rs1_busy_stop", 64'(busy[1]), 64'd0);
    pass_in[1] = 1'b0;
    active[1]  = 1'b0;
    tick(1);

    // Abort on channel 3, then reset mid-run.
    active[3] = 1'b1;
    tick(1);
    tick(37);
    chk("ab3_count37", cc[3], 64'd37);
    active[3] = 1'b0;
    tick(1);
    chk("ab3_busy", 64'(busy[3]), 64'd0);
    chk("ab3_count", cc[3], 64'd37);
    chk("ab3_tmo", 64'(tmo[3]), 64'd0);
    active[3] = 1'b1;
    tick(1);
    tick(12);
    chk("rr3_count12", cc[3], 64'd12);
    rst = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_count%0d", i), cc[i], 64'd0);
    end
    chk("rr_tmo", 64'(tmo), 64'd0);
    chk("rr_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick(1);
    chk("rr3_restart_busy", 64'(busy[3]), 64'd1);
    chk("rr3_restart_count", cc[3], 64'd0);
    tick(3);
    chk("rr3_count3", cc[3], 64'd3);
    active[3] = 1'b0;
    tick(1);

    // Staggered starts on all channels.
    active[0] = 1'b1;
    tick(1);
    active[1] = 1'b1;
    tick(1);
    active[2] = 1'b1;
    tick(1);
    active[3] = 1'b1;
    tick(1);
    chk("ind_c0_a", cc[0], 64'd3);
    chk("ind_c1_a", cc[1], 64'd2);
    chk("ind_c2_a", cc[2], 64'd1);
    chk("ind_c3_a", cc[3], 64'd0);
    tick(5);
    pass_in[1] = 1'b1;
    tick(1);
    chk("ind_c0_b", cc[0], 64'd9);
    chk("ind_c1_b", cc[1], 64'd7);
    chk("ind_c2_b", cc[2], 64'd7);
    chk("ind_c3_b", cc[3], 64'd6);
    chk("ind_busy", 64'(busy), 64'b1101);
    pass_in[1] = 1'b0;
    active     = '0;
    tick(1);

    // Saturation on the 8-bit instance.
    s_active = 1'b1;
    tick(1);
    tick(200);
    chk("sat_count200", 64'(s_cc[0]), 64'd200);
    tick(100);
    chk("sat_count255", 64'(s_cc[0]), 64'd255);
    chk("sat_busy", 64'(s_busy), 64'd1);
    tick(50);
    chk("sat_hold", 64'(s_cc[0]), 64'd255);
    chk("sat_tmo", 64'(s_tmo), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
